// File: rtl/uart_fifo_wb.sv
// uart_fifo_wb: Wishbone UART with TX/RX FIFOs, runtime baud divisor, 1/2 stop bits and watermark IRQ
module uart_fifo_wb #(
    parameter int CLOCK_FREQ_HZ = 115200 * 32,
    parameter int BAUD_RATE     = 115200,
    parameter int FIFO_DEPTH    = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [2:0]  ADR_I,
    input  logic [31:0] DAT_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    input  logic        rxd,
    output logic        txd,
    output logic        interrupt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] DIV_RST = 16'(CLOCK_FREQ_HZ / BAUD_RATE - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t tx_state, tx_next, rx_state, rx_next;
    logic txen, nstop, rxen, overrun, tx_two;
    logic [7:0] txcnt, rxcnt;
    logic [1:0] ie, ip, rx_sync;
    logic [15:0] div, tx_cnt, rx_cnt;
    logic [2:0] tx_bit, rx_bit;
    logic [31:0] rdata;
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] tx_sh, rx_sh;
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0] tx_count, rx_count;
    logic wr, rd, req, div_wr, tx_push, tx_pop, rx_push, rx_pop, rx_frame_ok;
    logic tx_full, tx_empty, rx_full, rx_empty, tx_tick, rx_tick, tx_last, rx_last, rx_s, rx_prev;
    logic unused;
    assign unused = &{1'b0, DAT_I[30:24]};
    assign req = CYC_I && STB_I && !ACK_O;
    assign wr = ACK_O && WE_I;
    assign rd = ACK_O && !WE_I;
    assign div_wr = wr && ADR_I == 3'd6;
    assign tx_full = tx_count == CW'(FIFO_DEPTH);
    assign rx_full = rx_count == CW'(FIFO_DEPTH);
    assign tx_empty = tx_count == '0;
    assign rx_empty = rx_count == '0;
    assign tx_push = wr && ADR_I == 3'd0 && !tx_full;
    assign rx_pop = rd && ADR_I == 3'd1 && !rx_empty;
    assign ip = {9'(rx_count) > {1'b0, rxcnt}, 9'(tx_count) < {1'b0, txcnt}};
    always_comb begin
        rdata = '0;
        case (ADR_I)
            3'd0: rdata = {tx_full, 31'b0};
            3'd1: rdata = {rx_empty, 23'b0, rx_empty ? 8'b0 : 8'(rx_mem[rx_rp])};
            3'd2: rdata = {8'b0, txcnt, 14'b0, nstop, txen};
            3'd3: rdata = {overrun, 7'b0, rxcnt, 15'b0, rxen};
            3'd4: rdata = {30'b0, ie};
            3'd5: rdata = {30'b0, ip};
            3'd6: rdata = {16'b0, div};
            default: rdata = '0;
        endcase
    end
    // Side effects use the address/data the master still holds during the ACK cycle.
    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I) begin
            ACK_O <= 1'b0;
            DAT_O <= '0;
            interrupt <= 1'b0;
            {txen, nstop, rxen, overrun} <= '0;
            {txcnt, rxcnt, ie} <= '0;
            div <= DIV_RST;
        end else begin
            ACK_O <= req;
            DAT_O <= req && !WE_I ? rdata : '0;
            interrupt <= |(ie & ip);
            if (wr && ADR_I == 3'd2) {txcnt, nstop, txen} <= {DAT_I[23:16], DAT_I[1:0]};
            if (wr && ADR_I == 3'd3) {rxcnt, rxen} <= {DAT_I[23:16], DAT_I[0]};
            if (wr && ADR_I == 3'd3 && DAT_I[31]) overrun <= 1'b0;
            if (rx_push && rx_full) overrun <= 1'b1;
            if (wr && ADR_I == 3'd4) ie <= DAT_I[1:0];
            if (div_wr) div <= DAT_I[15:0];
        end
    always_ff @(posedge CLK_I) begin
        if (tx_push) tx_mem[tx_wp] <= DAT_I[DATA_BITS-1:0];
        if (rx_push && !rx_full) rx_mem[rx_wp] <= rx_sh;
    end
    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I) begin
            {tx_wp, tx_rp, rx_wp, rx_rp} <= '0;
            {tx_count, rx_count} <= '0;
        end else begin
            tx_wp <= tx_wp + AW'(tx_push);
            tx_rp <= tx_rp + AW'(tx_pop);
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
            rx_wp <= rx_wp + AW'(rx_push && !rx_full);
            rx_rp <= rx_rp + AW'(rx_pop);
            rx_count <= rx_count + CW'(rx_push && !rx_full) - CW'(rx_pop);
        end
    assign tx_tick = tx_cnt == div;
    assign tx_last = tx_bit == 3'(DATA_BITS - 1);
    assign txd = tx_state == START ? 1'b0 : tx_state == DATA ? tx_sh[0] : 1'b1;
    // The stop state chains straight into the next start so back-to-back frames have no idle gap.
    always_comb begin
        tx_next = tx_state;
        tx_pop = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_pop = txen && !tx_empty;
                tx_next = tx_pop ? START : IDLE;
            end
            START: tx_next = tx_tick ? DATA : START;
            DATA: tx_next = tx_tick && tx_last ? STOP : DATA;
            STOP: if (tx_tick && (!tx_two || tx_bit[0])) begin
                tx_pop = txen && !tx_empty;
                tx_next = tx_pop ? START : IDLE;
            end
            default: tx_next = IDLE;
        endcase
    end
    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I) begin
            tx_state <= IDLE;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh <= '0;
            tx_two <= 1'b0;
        end else begin
            tx_state <= tx_next;
            tx_cnt <= tx_state == IDLE || tx_tick || div_wr ? '0 : tx_cnt + 16'd1;
            if (tx_pop) begin
                tx_sh <= tx_mem[tx_rp];
                tx_two <= nstop;
                tx_bit <= '0;
            end else if (tx_tick && tx_state == DATA) begin
                tx_sh <= tx_sh >> 1;
                tx_bit <= tx_last ? 3'd0 : tx_bit + 3'd1;
            end else if (tx_tick && tx_state == STOP) tx_bit <= tx_bit + 3'd1;
        end
    assign rx_s = rx_sync[1];
    assign rx_tick = rx_cnt == (rx_state == START ? div >> 1 : div);
    assign rx_last = rx_bit == 3'(DATA_BITS - 1);
    assign rx_frame_ok = rx_state == STOP && rx_tick;
    assign rx_push = rx_frame_ok && rx_s;
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE: rx_next = rxen && rx_prev && !rx_s ? START : IDLE;
            START: rx_next = rx_tick ? (rx_s ? IDLE : DATA) : START;
            DATA: rx_next = rx_tick && rx_last ? STOP : DATA;
            STOP: rx_next = rx_tick ? IDLE : STOP;
            default: rx_next = IDLE;
        endcase
    end
    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I) begin
            rx_state <= IDLE;
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh <= '0;
        end else begin
            rx_sync <= {rx_sync[0], rxd};
            rx_prev <= rx_s;
            rx_state <= rx_next;
            rx_cnt <= rx_state == IDLE || rx_tick || div_wr ? '0 : rx_cnt + 16'd1;
            if (rx_state == IDLE) rx_bit <= '0;
            else if (rx_tick && rx_state == DATA) begin
                rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
                rx_bit <= rx_bit + 3'd1;
            end
        end
endmodule

// File: tb/tb_uart_fifo_wb.sv
// tb_uart_fifo_wb: directed self-checking bench for uart_fifo_wb at default parameters (div=31)
module tb_uart_fifo_wb;
    logic CLK_I = 1'b0, RST_I = 1'b1, CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
    logic [2:0] ADR_I = '0;
    logic [31:0] DAT_I = '0, DAT_O;
    logic ACK_O, txd, interrupt;
    logic loop = 1'b0, rxd_drv = 1'b1;
    wire rxd = loop ? txd : rxd_drv;
    int n_chk = 0, n_fail = 0;
    always #5 CLK_I = ~CLK_I;
    uart_fifo_wb dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .ADR_I(ADR_I), .DAT_I(DAT_I), .CYC_I(CYC_I),
        .STB_I(STB_I), .WE_I(WE_I), .DAT_O(DAT_O), .ACK_O(ACK_O), .rxd(rxd),
        .txd(txd), .interrupt(interrupt)
    );
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    task automatic bus(input logic we, input logic [2:0] adr, input logic [31:0] wdat, output logic [31:0] rdat);
        int t = 0;
        @(negedge CLK_I);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = wdat;
        @(negedge CLK_I);
        while (!ACK_O && t < 8) begin
            @(negedge CLK_I);
            t++;
        end
        rdat = DAT_O;
        if (!ACK_O) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout adr=%0d: ack=%b, required 1", adr, ACK_O);
        end
        @(negedge CLK_I);
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    endtask
    task automatic wr(input logic [2:0] adr, input logic [31:0] d);
        logic [31:0] dummy;
        bus(1'b1, adr, d, dummy);
    endtask
    task automatic rd(input logic [2:0] adr, output logic [31:0] d);
        bus(1'b0, adr, 32'h0, d);
    endtask
    task automatic do_reset();
        RST_I = 1'b1;
        loop = 1'b0;
        rxd_drv = 1'b1;
        repeat (3) @(negedge CLK_I);
        RST_I = 1'b0;
    endtask
    task automatic get_frame(output logic [7:0] b, output logic ok);
        int t = 0;
        ok = 1'b0;
        b = '0;
        while (txd !== 1'b0 && t < 2000) begin
            @(negedge CLK_I);
            t++;
        end
        if (txd !== 1'b0) return;
        repeat (16) @(negedge CLK_I);
        if (txd !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (32) @(negedge CLK_I);
            b[i] = txd;
        end
        repeat (32) @(negedge CLK_I);
        ok = txd === 1'b1;
    endtask
    task automatic run_len(input logic v, output int n);
        n = 0;
        while (txd === v && n < 200) begin
            n++;
            @(negedge CLK_I);
        end
    endtask
    task automatic test_reset();
        logic [31:0] d;
        @(negedge CLK_I);
        n_chk++;
        if ({txd, ACK_O, interrupt, DAT_O} !== {3'b100, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: txd/ack/irq/dat=%b%b%b/%h, required 100/00000000", txd, ACK_O, interrupt, DAT_O);
        end
        RST_I = 1'b0;
        wr(3'd2, 32'h1);
        wr(3'd0, 32'h0);
        repeat (100) @(negedge CLK_I);
        n_chk++;
        if (txd !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_txd: txd=%b, required 0", txd);
        end
        #3 RST_I = 1'b1;
        #1;
        n_chk++;
        if (txd !== 1'b1 || DAT_O !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: txd=%b dat=%h, required 1/00000000", txd, DAT_O);
        end
        repeat (2) @(negedge CLK_I);
        RST_I = 1'b0;
        rd(3'd1, d);
        n_chk++;
        if (d !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL reset_rxdata: got %h, required 80000000", d);
        end
        rd(3'd6, d);
        n_chk++;
        if (d !== 32'd31) begin
            n_fail++;
            $display("FAIL reset_div: got %h, required 0000001f", d);
        end
        rd(3'd2, d);
        n_chk++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_txctrl: got %h, required 00000000", d);
        end
        @(negedge CLK_I);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 3'd6;
        @(negedge CLK_I);
        n_chk++;
        if (ACK_O !== 1'b1 || DAT_O !== 32'd31) begin
            n_fail++;
            $display("FAIL ack_first: ack=%b dat=%h, required 1/0000001f", ACK_O, DAT_O);
        end
        @(negedge CLK_I);
        n_chk++;
        if (ACK_O !== 1'b0 || DAT_O !== 32'h0) begin
            n_fail++;
            $display("FAIL ack_single: ack=%b dat=%h, required 0/00000000", ACK_O, DAT_O);
        end
        CYC_I = 1'b0; STB_I = 1'b0;
    endtask
    task automatic test_regs();
        logic [31:0] d;
        do_reset();
        wr(3'd2, 32'h00AB_0003);
        rd(3'd2, d);
        n_chk++;
        if (d !== 32'h00AB_0003) begin
            n_fail++;
            $display("FAIL txctrl_rw: got %h, required 00ab0003", d);
        end
        wr(3'd3, 32'h7F12_FFFF);
        rd(3'd3, d);
        n_chk++;
        if (d !== 32'h0012_0001) begin
            n_fail++;
            $display("FAIL rxctrl_rw: got %h, required 00120001", d);
        end
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd7, d);
        n_chk++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped: got %h, required 00000000", d);
        end
        rd(3'd5, d);
        n_chk++;
        if (d !== 32'h1) begin
            n_fail++;
            $display("FAIL ip_txwm: got %h, required 00000001", d);
        end
        wr(3'd4, 32'h3);
        rd(3'd4, d);
        n_chk++;
        if (d !== 32'h3 || interrupt !== 1'b1) begin
            n_fail++;
            $display("FAIL ie_irq: ie=%h irq=%b, required 00000003/1", d, interrupt);
        end
    endtask
    task automatic test_loopback();
        logic [31:0] d;
        do_reset();
        loop = 1'b1;
        wr(3'd2, 32'h1);
        wr(3'd3, 32'h1);
        wr(3'd0, 32'hA5);
        wr(3'd0, 32'h3C);
        repeat (800) @(negedge CLK_I);
        rd(3'd1, d);
        n_chk++;
        if (d !== 32'hA5) begin
            n_fail++;
            $display("FAIL loop_byte0: got %h, required 000000a5", d);
        end
        rd(3'd1, d);
        n_chk++;
        if (d !== 32'h3C) begin
            n_fail++;
            $display("FAIL loop_byte1: got %h, required 0000003c", d);
        end
        rd(3'd1, d);
        n_chk++;
        if (d !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL loop_empty: got %h, required 80000000", d);
        end
    endtask
    task automatic test_tx_full();
        logic [31:0] d;
        logic [7:0] b;
        logic ok;
        int lows = 0;
        do_reset();
        for (int i = 0; i < 7; i++) wr(3'd0, 32'(i));
        rd(3'd0, d);
        n_chk++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL txfull_7: got %h, required 00000000", d);
        end
        wr(3'd0, 32'h7);
        rd(3'd0, d);
        n_chk++;
        if (d !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL txfull_8: got %h, required 80000000", d);
        end
        wr(3'd0, 32'hEE);
        wr(3'd2, 32'h1);
        for (int i = 0; i < 8; i++) begin
            get_frame(b, ok);
            n_chk++;
            if (!ok || b !== 8'(i)) begin
                n_fail++;
                $display("FAIL txfull_frame%0d: byte=%h ok=%b, required %h/1", i, b, ok, 8'(i));
            end
        end
        repeat (400) begin
            @(negedge CLK_I);
            if (txd === 1'b0) lows++;
        end
        n_chk++;
        if (lows != 0) begin
            n_fail++;
            $display("FAIL txfull_extra: low clocks after 8 frames=%0d, required 0", lows);
        end
    endtask
    task automatic test_frame_timing();
        int n, t = 0;
        do_reset();
        wr(3'd6, 32'd3);
        wr(3'd0, 32'h01);
        wr(3'd0, 32'h01);
        wr(3'd2, 32'h3);
        while (txd !== 1'b0 && t < 100) begin
            @(negedge CLK_I);
            t++;
        end
        run_len(1'b0, n);
        n_chk++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL timing_start: low %0d clocks, required 4", n);
        end
        run_len(1'b1, n);
        n_chk++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL timing_bit0: high %0d clocks, required 4", n);
        end
        run_len(1'b0, n);
        n_chk++;
        if (n != 28) begin
            n_fail++;
            $display("FAIL timing_zeros: low %0d clocks, required 28", n);
        end
        run_len(1'b1, n);
        n_chk++;
        if (n != 8) begin
            n_fail++;
            $display("FAIL timing_stop2: high %0d clocks, required 8", n);
        end
        run_len(1'b0, n);
        n_chk++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL timing_b2b_start: low %0d clocks, required 4", n);
        end
    endtask
    task automatic test_overrun();
        logic [31:0] d;
        do_reset();
        loop = 1'b1;
        wr(3'd2, 32'h1);
        wr(3'd3, 32'h1);
        for (int i = 0; i < 9; i++) wr(3'd0, 32'h10 + 32'(i));
        repeat (3100) @(negedge CLK_I);
        rd(3'd3, d);
        n_chk++;
        if (d !== 32'h8000_0001) begin
            n_fail++;
            $display("FAIL overrun_set: got %h, required 80000001", d);
        end
        rd(3'd5, d);
        n_chk++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL overrun_ip: got %h, required 00000002", d);
        end
        for (int i = 0; i < 8; i++) begin
            rd(3'd1, d);
            n_chk++;
            if (d !== 32'h10 + 32'(i)) begin
                n_fail++;
                $display("FAIL overrun_byte%0d: got %h, required %h", i, d, 32'h10 + 32'(i));
            end
        end
        rd(3'd1, d);
        n_chk++;
        if (d !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL overrun_empty: got %h, required 80000000", d);
        end
        wr(3'd3, 32'h8000_0001);
        rd(3'd3, d);
        n_chk++;
        if (d !== 32'h1) begin
            n_fail++;
            $display("FAIL overrun_clear: got %h, required 00000001", d);
        end
    endtask
    task automatic test_irq();
        logic [31:0] d;
        do_reset();
        loop = 1'b1;
        wr(3'd4, 32'h2);
        wr(3'd3, 32'h1);
        wr(3'd2, 32'h1);
        n_chk++;
        if (interrupt !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_idle: irq=%b, required 0", interrupt);
        end
        wr(3'd0, 32'h5A);
        repeat (400) @(negedge CLK_I);
        n_chk++;
        if (interrupt !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_rx: irq=%b, required 1", interrupt);
        end
        rd(3'd1, d);
        n_chk++;
        if (d !== 32'h5A || interrupt !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_pop: data=%h irq=%b, required 0000005a/1", d, interrupt);
        end
        @(posedge CLK_I);
        #1;
        n_chk++;
        if (interrupt !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clear: irq=%b, required 0", interrupt);
        end
        loop = 1'b0;
        repeat (5) @(negedge CLK_I);
        rxd_drv = 1'b0;
        repeat (2) @(negedge CLK_I);
        rxd_drv = 1'b1;
        repeat (400) @(negedge CLK_I);
        rd(3'd1, d);
        n_chk++;
        if (d !== 32'h8000_0000 || interrupt !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch: rxdata=%h irq=%b, required 80000000/0", d, interrupt);
        end
    endtask
    initial begin
        test_reset();
        test_regs();
        test_loopback();
        test_tx_full();
        test_frame_timing();
        test_overrun();
        test_irq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
